test_status_monitor: RTL and testbench
======================================

// Module: test_status_monitor
// PURPOSE
//   Bus-side source for the test-tools pass/fail checker. Snoops the PicoBlaze output-port bus
//   and decodes firmware writes to a 4-byte mailbox into registered results:
//   - test_done / test_passed / test_failed levels
//   - a saturating fail count, checkpoint pulses, 32-bit value/expected compares
//   - a watchdog timeout
//   Instantiated in the testbench next to the processor and drives the checker's terminate signals.
// PARAMETERS
//   BASE_ADDR    8'hF0  port_id of mailbox byte 0; mailbox occupies BASE_ADDR..BASE_ADDR+3
//   WDOG_CYCLES  100000 idle clks before timeout; 0 disables watchdog
// PORTS
//   clk              in   1   system clock, all state on rising edge
//   rst_n            in   1   asynchronous active-low reset
//   port_id          in   8   PicoBlaze port address
//   out_port         in   8   PicoBlaze write data
//   write_strobe     in   1   PicoBlaze write qualifier, one clk wide
//   checkpoint       out  8   last checkpoint byte written
//   checkpoint_valid out  1   one-clk pulse when checkpoint updates
//   value            out  32  value shift register
//   expected         out  32  expected shift register
//   compare_valid    out  1   one-clk pulse, a compare completed
//   compare_match    out  1   result of last compare (value == expected)
//   fail_count       out  32  saturating mismatch/fail counter
//   test_done        out  1   sticky, end of test reached
//   test_passed      out  1   sticky, done with fail_count == 0 and no timeout
//   test_failed      out  1   sticky, FAIL command, done with fails, or timeout
//   timeout          out  1   sticky, watchdog expired
// BEHAVIOUR
//   - Reset: every output and internal register = 0; watchdog counter = 0.
//   - Hit = write_strobe && port_id in BASE_ADDR..+3, sampled on the rising clk edge.
//     All results are registered and visible the clk after the strobe.
//   - Offset 0, CMD:
//       01 PASS    -> test_done=1; test_passed=1 only if fail_count==0, else test_failed=1
//       02 FAIL    -> test_done=1, test_failed=1, fail_count+1 (saturating)
//       03 DONE    -> test_done=1; passed/failed chosen by fail_count==0
//       04 COMPARE -> next clk: compare_valid=1, compare_match=(value==expected);
//                     on mismatch fail_count+1 on the same edge
//       05 CLEAR   -> fail_count, value, expected, checkpoint, compare_match = 0;
//                     does NOT clear sticky done/passed/failed/timeout
//       any other code -> ignored
//   - Offset 1, CHECKPOINT: checkpoint<=out_port; checkpoint_valid=1 for one clk.
//   - Offset 2, VALUE: value <= {value[23:0], out_port}; 4 writes MSB-first load a word.
//   - Offset 3, EXPECT: expected <= {expected[23:0], out_port}; same rule as VALUE.
//   - fail_count saturates at 32'hFFFF_FFFF and never wraps.
//   - Terminal state: once test_done or timeout is 1, all further hits are ignored until
//     reset, including CLEAR and COMPARE. passed and failed are mutually exclusive.
//   - Watchdog (WDOG_CYCLES != 0):
//       counter clears on any hit and increments otherwise
//       when it reaches WDOG_CYCLES-1: timeout=1, test_failed=1, test_done=1
//       the counter then holds
//       a hit on the expiry clk wins: counter clears and no timeout
//       WDOG_CYCLES==0 keeps timeout at 0 permanently
//   - Writes outside the mailbox window are ignored and do not feed the watchdog.
//   - Async reset mid-test returns every register to 0 immediately, regardless of clk.
//   - Write with write_strobe=0 has no effect; back-to-back strobes each take effect.
// TESTING
//   1 reset -> all outputs 0; write CMD 03 with no fails -> next clk test_done=1,
//     test_passed=1, test_failed=0
//   2 VALUE bytes DE,AD,BE,EF; EXPECT bytes DE,AD,BE,EE; CMD 04 ->
//     compare_valid pulse, compare_match=0, fail_count=1;
//     then EXPECT EF + CMD 04 -> expected=ADBEEEEF, mismatch, fail_count=2
//   3 CHECKPOINT 5A -> checkpoint=5A, checkpoint_valid high exactly 1 clk;
//     write to port F7 -> no change
//   4 WDOG_CYCLES=16, no writes -> timeout, test_failed, test_done high on the 16th clk after reset;
//     repeat with a CHECKPOINT write on the expiry clk -> no timeout
//   5 CMD 02 then CMD 05 then CMD 01 -> test_failed=1, fail_count stays 1
//     (post-done writes ignored), test_passed=0
//   6 assert rst_n low mid-compare sequence -> all outputs 0 asynchronously;
//     release, CMD 01 -> test_passed=1

Source files
------------

// File: rtl/test_status_monitor.sv
// Snoops the PicoBlaze output-port bus and decodes firmware writes to a 4-byte mailbox
// into registered pass/fail results, compare results, checkpoints and a watchdog timeout.
module test_status_monitor #(
    parameter logic [7:0]  BASE_ADDR   = 8'hF0,
    parameter int unsigned WDOG_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  port_id,
    input  logic [7:0]  out_port,
    input  logic        write_strobe,
    output logic [7:0]  checkpoint,
    output logic        checkpoint_valid,
    output logic [31:0] value,
    output logic [31:0] expected,
    output logic        compare_valid,
    output logic        compare_match,
    output logic [31:0] fail_count,
    output logic        test_done,
    output logic        test_passed,
    output logic        test_failed,
    output logic        timeout
);

    localparam logic [7:0] CMD_PASS    = 8'h01;
    localparam logic [7:0] CMD_FAIL    = 8'h02;
    localparam logic [7:0] CMD_DONE    = 8'h03;
    localparam logic [7:0] CMD_COMPARE = 8'h04;
    localparam logic [7:0] CMD_CLEAR   = 8'h05;

    localparam logic        WDOG_EN   = (WDOG_CYCLES != 0);
    localparam logic [31:0] WDOG_LAST = (WDOG_CYCLES == 0) ? 32'd0 : 32'(WDOG_CYCLES - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [7:0]  checkpoint_q,       checkpoint_d;
    logic        checkpoint_valid_q, checkpoint_valid_d;
    logic [31:0] value_q,            value_d;
    logic [31:0] expected_q,         expected_d;
    logic        compare_valid_q,    compare_valid_d;
    logic        compare_match_q,    compare_match_d;
    logic [31:0] fail_count_q,       fail_count_d;
    logic        test_done_q,        test_done_d;
    logic        test_passed_q,      test_passed_d;
    logic        test_failed_q,      test_failed_d;
    logic        timeout_q,          timeout_d;
    logic [31:0] wdog_q,             wdog_d;

    logic [8:0]  offset;
    logic        hit;
    logic        terminal;

    always_comb begin
        checkpoint_d       = checkpoint_q;
        checkpoint_valid_d = 1'b0;
        value_d            = value_q;
        expected_d         = expected_q;
        compare_valid_d    = 1'b0;
        compare_match_d    = compare_match_q;
        fail_count_d       = fail_count_q;
        test_done_d        = test_done_q;
        test_passed_d      = test_passed_q;
        test_failed_d      = test_failed_q;
        timeout_d          = timeout_q;
        wdog_d             = wdog_q;

        // Nine-bit difference keeps ports below BASE_ADDR from wrapping into the window.
        offset   = {1'b0, port_id} - {1'b0, BASE_ADDR};
        hit      = write_strobe && (offset < 9'd4);
        terminal = test_done_q || timeout_q;

        if (hit && !terminal) begin
            case (offset[1:0])
                2'd0: begin
                    case (out_port)
                        CMD_PASS, CMD_DONE: begin
                            test_done_d = 1'b1;
                            if (fail_count_q == 32'd0) test_passed_d = 1'b1;
                            else                       test_failed_d = 1'b1;
                        end
                        CMD_FAIL: begin
                            test_done_d   = 1'b1;
                            test_failed_d = 1'b1;
                            fail_count_d  = sat_inc(fail_count_q);
                        end
                        CMD_COMPARE: begin
                            compare_valid_d = 1'b1;
                            compare_match_d = (value_q == expected_q);
                            if (value_q != expected_q) fail_count_d = sat_inc(fail_count_q);
                        end
                        CMD_CLEAR: begin
                            fail_count_d    = 32'd0;
                            value_d         = 32'd0;
                            expected_d      = 32'd0;
                            checkpoint_d    = 8'd0;
                            compare_match_d = 1'b0;
                        end
                        default: begin end
                    endcase
                end
                2'd1: begin
                    checkpoint_d       = out_port;
                    checkpoint_valid_d = 1'b1;
                end
                2'd2:    value_d    = {value_q[23:0], out_port};
                default: expected_d = {expected_q[23:0], out_port};
            endcase
        end

        // Watchdog freezes once the test is over so passed/failed stay exclusive.
        if (WDOG_EN && !terminal) begin
            if (hit) begin
                wdog_d = 32'd0;
            end else if (wdog_q == WDOG_LAST) begin
                timeout_d     = 1'b1;
                test_failed_d = 1'b1;
                test_done_d   = 1'b1;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checkpoint_q       <= 8'd0;
            checkpoint_valid_q <= 1'b0;
            value_q            <= 32'd0;
            expected_q         <= 32'd0;
            compare_valid_q    <= 1'b0;
            compare_match_q    <= 1'b0;
            fail_count_q       <= 32'd0;
            test_done_q        <= 1'b0;
            test_passed_q      <= 1'b0;
            test_failed_q      <= 1'b0;
            timeout_q          <= 1'b0;
            wdog_q             <= 32'd0;
        end else begin
            checkpoint_q       <= checkpoint_d;
            checkpoint_valid_q <= checkpoint_valid_d;
            value_q            <= value_d;
            expected_q         <= expected_d;
            compare_valid_q    <= compare_valid_d;
            compare_match_q    <= compare_match_d;
            fail_count_q       <= fail_count_d;
            test_done_q        <= test_done_d;
            test_passed_q      <= test_passed_d;
            test_failed_q      <= test_failed_d;
            timeout_q          <= timeout_d;
            wdog_q             <= wdog_d;
        end
    end

    assign checkpoint       = checkpoint_q;
    assign checkpoint_valid = checkpoint_valid_q;
    assign value            = value_q;
    assign expected         = expected_q;
    assign compare_valid    = compare_valid_q;
    assign compare_match    = compare_match_q;
    assign fail_count       = fail_count_q;
    assign test_done        = test_done_q;
    assign test_passed      = test_passed_q;
    assign test_failed      = test_failed_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Scoreboard bench: two monitors (watchdog 16 and watchdog disabled) share one bus;
// a mailbox reference model predicts every cycle's outputs, a monitor process compares.
module tb_test_status_monitor;

    localparam logic [7:0] BASE = 8'hF0;

    typedef logic [110:0] snap_t;

    typedef struct {
        logic [7:0]  cp;
        logic        cpv;
        logic [31:0] val;
        logic [31:0] exp;
        logic        cv;
        logic        cm;
        longint      fails;
        logic        done;
        logic        passed;
        logic        failed;
        logic        tmo;
        int          idle;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  port_id = 8'd0;
    logic [7:0]  out_port = 8'd0;
    logic        write_strobe = 1'b0;

    logic [7:0]  cp_a, cp_b;
    logic        cpv_a, cpv_b, cv_a, cv_b, cm_a, cm_b;
    logic [31:0] val_a, val_b, exp_a, exp_b, fc_a, fc_b;
    logic        done_a, done_b, pass_a, pass_b, fail_a, fail_b, tmo_a, tmo_b;

    test_status_monitor #(.BASE_ADDR(BASE), .WDOG_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .checkpoint(cp_a), .checkpoint_valid(cpv_a),
        .value(val_a), .expected(exp_a), .compare_valid(cv_a), .compare_match(cm_a),
        .fail_count(fc_a), .test_done(done_a), .test_passed(pass_a),
        .test_failed(fail_a), .timeout(tmo_a)
    );

    test_status_monitor #(.BASE_ADDR(BASE), .WDOG_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .checkpoint(cp_b), .checkpoint_valid(cpv_b),
        .value(val_b), .expected(exp_b), .compare_valid(cv_b), .compare_match(cm_b),
        .fail_count(fc_b), .test_done(done_b), .test_passed(pass_b),
        .test_failed(fail_b), .timeout(tmo_b)
    );

    always #5 clk = ~clk;

    snap_t snap_a, snap_b;
    assign snap_a = {cp_a, cpv_a, val_a, exp_a, cv_a, cm_a, fc_a, done_a, pass_a, fail_a, tmo_a};
    assign snap_b = {cp_b, cpv_b, val_b, exp_b, cv_b, cm_b, fc_b, done_b, pass_b, fail_b, tmo_b};

    snap_t   qa[$];
    snap_t   qb[$];
    mstate_t ma, mb;
    int      checks_total  = 0;
    int      checks_passed = 0;

    function automatic mstate_t model_zero();
        mstate_t z;
        z.cp = 8'd0; z.cpv = 1'b0; z.val = 32'd0; z.exp = 32'd0;
        z.cv = 1'b0; z.cm = 1'b0; z.fails = 0; z.done = 1'b0;
        z.passed = 1'b0; z.failed = 1'b0; z.tmo = 1'b0; z.idle = 0;
        return z;
    endfunction

    function automatic snap_t pack(mstate_t s);
        return {s.cp, s.cpv, s.val, s.exp, s.cv, s.cm, 32'(s.fails),
                s.done, s.passed, s.failed, s.tmo};
    endfunction

    function automatic longint bump(longint f);
        return (f < 64'hFFFF_FFFF) ? f + 1 : f;
    endfunction

    // Mailbox semantics stated directly: what one bus cycle does to the visible results.
    function automatic mstate_t model_next(mstate_t s, int wdog, logic stb,
                                           logic [7:0] p, logic [7:0] d);
        mstate_t n = s;
        int  off  = int'(p) - int'(BASE);
        bit  hit  = stb && off >= 0 && off <= 3;
        bit  over = s.done || s.tmo;
        n.cpv = 1'b0;
        n.cv  = 1'b0;
        if (hit && !over) begin
            if (off == 0) begin
                if (d == 8'h01 || d == 8'h03) begin
                    n.done = 1'b1;
                    if (s.fails == 0) n.passed = 1'b1; else n.failed = 1'b1;
                end else if (d == 8'h02) begin
                    n.done = 1'b1; n.failed = 1'b1; n.fails = bump(s.fails);
                end else if (d == 8'h04) begin
                    n.cv = 1'b1;
                    n.cm = (s.val == s.exp);
                    if (s.val != s.exp) n.fails = bump(s.fails);
                end else if (d == 8'h05) begin
                    n.fails = 0; n.val = 32'd0; n.exp = 32'd0; n.cp = 8'd0; n.cm = 1'b0;
                end
            end else if (off == 1) begin
                n.cp = d; n.cpv = 1'b1;
            end else if (off == 2) begin
                n.val = (s.val << 8) | {24'd0, d};
            end else begin
                n.exp = (s.exp << 8) | {24'd0, d};
            end
        end
        if (wdog != 0 && !over) begin
            if (hit) n.idle = 0;
            else begin
                n.idle = s.idle + 1;
                if (n.idle == wdog) begin
                    n.tmo = 1'b1; n.failed = 1'b1; n.done = 1'b1;
                end
            end
        end
        return n;
    endfunction

    task automatic check_snap(input string name, input snap_t got, input snap_t want);
        checks_total++;
        if (got === want) checks_passed++;
        else $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    endtask

    // Monitor: every falling clock edge (and a reset assertion) presents a result to check.
    initial begin
        snap_t ea, eb;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check_snap("dut_wdog16", snap_a, ea);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check_snap("dut_wdog0", snap_b, eb);
            end
        end
    end

    task automatic step(input logic s, input logic [7:0] p, input logic [7:0] d);
        write_strobe = s;
        port_id      = p;
        out_port     = d;
        if (!rst_n) begin
            ma = model_zero();
            mb = model_zero();
        end else begin
            ma = model_next(ma, 16, s, p, d);
            mb = model_next(mb, 0, s, p, d);
        end
        qa.push_back(pack(ma));
        qb.push_back(pack(mb));
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        step(1'b1, p, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
    endtask

    // Reset asserted mid low-phase, away from any rising edge.
    task automatic apply_reset(input int hold);
        @(negedge clk);
        #2;
        write_strobe = 1'b0;
        ma = model_zero();
        mb = model_zero();
        qa.push_back(pack(ma));
        qb.push_back(pack(mb));
        rst_n = 1'b0;
        for (int i = 0; i < hold; i++) step(1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] pick_byte();
        int c = $urandom_range(3);
        if (c == 0) return 8'h00;
        if (c == 1) return 8'hFF;
        if (c == 2) return 8'hA5;
        return 8'($urandom);
    endfunction

    task automatic rand_step();
        logic       s;
        logic [7:0] p, d;
        int         c;
        if ($urandom_range(99) < 4) begin
            idle(18);
            return;
        end
        s = ($urandom_range(99) < 80);
        if ($urandom_range(99) < 85) p = BASE + 8'($urandom_range(3));
        else                         p = 8'($urandom);
        d = pick_byte();
        if (p == BASE) begin
            c = $urandom_range(99);
            if      (c < 45) d = 8'h04;
            else if (c < 60) d = 8'h05;
            else if (c < 65) d = 8'h01;
            else if (c < 70) d = 8'h02;
            else if (c < 75) d = 8'h03;
            else             d = 8'($urandom);
        end
        step(s, p, d);
    endtask

    initial begin
        ma = model_zero();
        mb = model_zero();
        @(posedge clk);
        #1;

        // Reset then DONE with no fails
        apply_reset(2);
        wr(8'hF0, 8'h03);
        idle(2);

        // Value/expected shift-in and two mismatching compares
        apply_reset(1);
        wr(8'hF2, 8'hDE); wr(8'hF2, 8'hAD); wr(8'hF2, 8'hBE); wr(8'hF2, 8'hEF);
        wr(8'hF3, 8'hDE); wr(8'hF3, 8'hAD); wr(8'hF3, 8'hBE); wr(8'hF3, 8'hEE);
        wr(8'hF0, 8'h04);
        idle(1);
        wr(8'hF3, 8'hEF);
        wr(8'hF0, 8'h04);
        idle(1);

        // Checkpoint pulse, out-of-window write, unstrobed write
        apply_reset(1);
        wr(8'hF1, 8'h5A);
        idle(2);
        wr(8'hF7, 8'h33);
        step(1'b0, 8'hF1, 8'h77);
        idle(1);

        // Watchdog expiry, then a hit exactly on the expiry clock
        apply_reset(1);
        idle(20);
        wr(8'hF1, 8'h12);
        apply_reset(1);
        idle(15);
        wr(8'hF1, 8'h11);
        idle(3);

        // FAIL makes the test terminal; CLEAR and PASS afterwards are ignored
        apply_reset(1);
        wr(8'hF0, 8'h02);
        wr(8'hF0, 8'h05);
        wr(8'hF0, 8'h01);
        idle(1);

        // Reset mid-compare sequence, then PASS
        apply_reset(1);
        wr(8'hF2, 8'h01); wr(8'hF2, 8'h02); wr(8'hF3, 8'h09);
        apply_reset(1);
        wr(8'hF0, 8'h01);
        idle(1);

        // Randomized segments, each starting from reset
        for (int seg = 0; seg < 30; seg++) begin
            apply_reset(1 + $urandom_range(1));
            for (int k = 0; k < 10 + int'($urandom_range(30)); k++) rand_step();
        end

        @(negedge clk);
        #3;
        checks_total++;
        if (qa.size() == 0 && qb.size() == 0) checks_passed++;
        else $display("FAIL scoreboard_drain got=%0d/%0d pending want=0/0", qa.size(), qb.size());

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
